// File: rtl/uc_pkg.sv
// Shared defaults for the micro-controller fetch path.
// Width and depth defaults live here so every block agrees on them.
package uc_pkg;
    localparam int UC_ADDR_WIDTH = 12;
    localparam int UC_DATA_WIDTH = 8;
    localparam int UC_DEPTH      = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/instr_prefetch_if.sv
// Flash read port plus instruction delivery port of the prefetch unit.
// master = prefetch side, slave = flash/consumer side.
interface instr_prefetch_if #(
    parameter int ADDR_WIDTH = uc_pkg::UC_ADDR_WIDTH,
    parameter int DATA_WIDTH = uc_pkg::UC_DATA_WIDTH
);
    import uc_pkg::*;

    logic                  flash_req;
    logic [ADDR_WIDTH-1:0] flash_addr;
    logic                  flash_ready;
    logic [DATA_WIDTH-1:0] flash_data;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_take;

    modport master (
        output flash_req, flash_addr, instr_valid, instr_data, instr_pc,
        input  flash_ready, flash_data, instr_take
    );

    modport slave (
        input  flash_req, flash_addr, instr_valid, instr_data, instr_pc,
        output flash_ready, flash_data, instr_take
    );
endinterface

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO with flush, occupancy count, full and empty.
// Latency: write visible at head the cycle after push; head read is combinational.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: streams sequential flash bytes into a small buffer, supports redirect.
// Latency: a flash transfer appears at instr_valid one cycle later; head read is zero-latency.
// Backpressure: flash_req drops when the buffer is full; flash_ready stalls hold flash_addr.
module instr_prefetch
    import uc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = UC_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = UC_DATA_WIDTH,
    parameter int                    DEPTH      = UC_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       fetch_en,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_addr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    instr_prefetch_if.master           bus
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_addr;
    entry_t                push_dat;
    entry_t                head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Gating with arst_n keeps the request low for the whole reset window.
    assign bus.flash_req  = arst_n & fetch_en & ~full & ~redirect;
    assign bus.flash_addr = fetch_addr;

    assign push     = bus.flash_req & bus.flash_ready;
    assign pop      = bus.instr_take & ~empty & ~redirect;
    assign push_dat = '{pc: fetch_addr, dat: bus.flash_data};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)       fetch_addr <= RESET_ADDR;
        else if (redirect) fetch_addr <= redirect_addr;
        else if (push)     fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
    end

    fifo_sync #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .flush    (redirect),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count),
        .full     (full),
        .empty    (empty)
    );

    // Stale storage must never leak onto the outputs while empty.
    assign bus.instr_valid = ~empty;
    assign bus.instr_data  = empty ? '0 : head.dat;
    assign bus.instr_pc    = empty ? '0 : head.pc;
endmodule
